// File: rtl/enc_pkg.sv
// Shared constants and helpers for the one-hot <-> binary encoder pair.
package enc_pkg;

    localparam int ENC_W  = 15;
    localparam int ENC_BW = 4;
    localparam int ENC_CW = 8;

    // First binary code that no legal one-hot word can produce.
    localparam logic [ENC_BW-1:0] ERR_CODE = ENC_BW'(ENC_W);

    // Returns 1 iff exactly one bit of word is set.
    function automatic logic onehot_ok(input logic [ENC_W-1:0] word);
        return (word != '0) && ((word & (word - ENC_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/enc_onehot2bin_if.sv
// Valid/ready stream bundle: one-hot word in, binary index plus error flag out.
interface enc_onehot2bin_if #(
    parameter int W  = enc_pkg::ENC_W,
    parameter int BW = enc_pkg::ENC_BW
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out;
    logic          out_err;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out, out_err
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out, out_err
    );
endinterface

// File: rtl/enc_onehot2bin_core.sv
// Combinational one-hot to binary encoder; any word that is not exactly
// one-hot maps to the reserved code W with err set.
module enc_onehot2bin_core
    import enc_pkg::*;
#(
    parameter int W  = ENC_W,
    parameter int BW = ENC_BW
) (
    input  logic [W-1:0]  word,
    output logic [BW-1:0] index,
    output logic          err
);

    // Selects every input position whose index has bit b set.
    function automatic logic [W-1:0] bit_mask(input int b);
        logic [W-1:0] m;
        m = '0;
        for (int k = 0; k < W; k++) begin
            m[k] = ((k >> b) & 1) != 0;
        end
        return m;
    endfunction

    logic [BW-1:0] raw_index;
    logic          zero_hot;
    logic          multi_hot;

    genvar gi;
    generate
        for (gi = 0; gi < BW; gi++) begin : g_index_bit
            assign raw_index[gi] = |(word & bit_mask(gi));
        end
    endgenerate

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign zero_hot  = (word == '0);
    assign multi_hot = ((word & (word - W'(1))) != '0);
    assign err       = zero_hot | multi_hot;
    assign index     = err ? BW'(W) : raw_index;

endmodule

// File: rtl/enc_onehot2bin.sv
// Registered one-hot to binary encoder with valid/ready handshake, one-cycle
// latency and a saturating count of accepted illegal words.
module enc_onehot2bin
    import enc_pkg::*;
#(
    parameter int W  = ENC_W,
    parameter int BW = ENC_BW,
    parameter int CW = ENC_CW
) (
    input  logic                clk,
    input  logic                rst,
    enc_onehot2bin_if.slave     bus,
    input  logic                err_clr,
    output logic [CW-1:0]       err_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          out_valid_reg;
    logic [BW-1:0] out_reg;
    logic          out_err_reg;
    logic [CW-1:0] err_cnt_reg;
    logic [CW-1:0] err_cnt_next;
    logic [BW-1:0] enc_index;
    logic          enc_err;
    logic          accept;

    enc_onehot2bin_core #(
        .W  (W),
        .BW (BW)
    ) u_core (
        .word  (bus.in),
        .index (enc_index),
        .err   (enc_err)
    );

    assign bus.in_ready = !out_valid_reg || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // An illegal accept coinciding with a clear still counts as one event.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (accept && enc_err) begin
            if (err_clr)
                err_cnt_next = CW'(1);
            else if (err_cnt_reg != CNT_MAX)
                err_cnt_next = err_cnt_reg + CW'(1);
        end else if (err_clr) begin
            err_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            out_err_reg   <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_reg       <= enc_index;
                out_err_reg   <= enc_err;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out       = out_reg;
    assign bus.out_err   = out_err_reg;
    assign err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_enc_onehot2bin.sv
// Directed bench for enc_onehot2bin: sweep, illegal words, backpressure,
// counter saturation/clear, asynchronous reset and a bin2onehot round trip.
module tb_enc_onehot2bin;
    import enc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       err_clr;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    enc_onehot2bin_if #(.W(15), .BW(4)) bus ();

    enc_onehot2bin #(.W(15), .BW(4), .CW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_clr (err_clr),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference binary-to-one-hot encoder; values >= 15 give an all-zero word.
    function automatic logic [14:0] bin2onehot(input logic [3:0] v);
        logic [15:0] wide;
        wide = 16'(1) << v;
        return wide[14:0];
    endfunction

    logic [14:0] ill_words [3];
    logic [3:0]  v;
    logic [14:0] w;

    initial begin
        ill_words[0] = 15'h0000;
        ill_words[1] = 15'h0005;
        ill_words[2] = 15'h7FFF;

        rst = 1'b1; err_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in = '0; bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out",       32'(bus.out), 0);
        chk("rst_out_err",   32'(bus.out_err), 0);
        chk("rst_err_cnt",   32'(err_cnt), 0);
        chk("rst_in_ready",  32'(bus.in_ready), 1);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);

        // Legal sweep, one word per cycle
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 15; k++) begin
            bus.in = 15'(1) << k;
            tick();
            chk("sweep_out",       32'(bus.out), 32'(k));
            chk("sweep_out_valid", 32'(bus.out_valid), 1);
            chk("sweep_out_err",   32'(bus.out_err), 0);
            chk("sweep_err_cnt",   32'(err_cnt), 0);
            $display("sweep in=%04h out=%0d err=%0d", bus.in, bus.out, bus.out_err);
        end

        // Illegal words: zero-hot, two-hot, all-hot
        for (int i = 0; i < 3; i++) begin
            bus.in = ill_words[i];
            tick();
            chk("illegal_out",     32'(bus.out), 32'hF);
            chk("illegal_out_err", 32'(bus.out_err), 1);
            chk("illegal_err_cnt", 32'(err_cnt), 32'(i + 1));
            $display("illegal in=%04h out=%0h err=%0d cnt=%0d", bus.in, bus.out, bus.out_err, err_cnt);
        end

        bus.in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 32'(bus.out_valid), 0);

        // Backpressure: accept 0x0100, then stall with a new word waiting
        bus.in_valid = 1'b1;
        bus.in = 15'h0100;
        tick();
        chk("bp_first_out", 32'(bus.out), 8);
        bus.out_ready = 1'b0;
        bus.in = 15'h0002;
        #1;
        chk("bp_in_ready_low", 32'(bus.in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_out",       32'(bus.out), 8);
            chk("bp_hold_out_valid", 32'(bus.out_valid), 1);
            chk("bp_hold_in_ready",  32'(bus.in_ready), 0);
            $display("stall cycle=%0d out=%0d in_ready=%0d", i, bus.out, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_out",     32'(bus.out), 1);
        chk("bp_release_out_err", 32'(bus.out_err), 0);
        chk("bp_err_cnt_kept",    32'(err_cnt), 3);

        // Saturation: 300 illegal words on top of the 3 already counted
        bus.in = 15'h0000;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_err_cnt", 32'(err_cnt), 255);
        $display("saturate cnt=%0d", err_cnt);
        tick();
        chk("sat_hold_err_cnt", 32'(err_cnt), 255);

        bus.in_valid = 1'b0;
        err_clr = 1'b1;
        tick();
        chk("clr_alone", 32'(err_cnt), 0);

        bus.in_valid = 1'b1;
        bus.in = 15'h0003;
        tick();
        chk("clr_with_illegal", 32'(err_cnt), 1);

        bus.in = 15'h0001;
        tick();
        chk("clr_with_legal", 32'(err_cnt), 0);
        chk("clr_with_legal_out", 32'(bus.out), 0);
        err_clr = 1'b0;

        // Reset mid-stall, asserted between clock edges
        bus.in = 15'h0003;
        tick();
        chk("prestall_err_cnt", 32'(err_cnt), 1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 0);
        chk("async_rst_out",       32'(bus.out), 0);
        chk("async_rst_err_cnt",   32'(err_cnt), 0);
        chk("async_rst_in_ready",  32'(bus.in_ready), 1);
        $display("async reset out_valid=%0d cnt=%0d", bus.out_valid, err_cnt);
        tick();
        #2;
        rst = 1'b0;
        tick();

        // Round trip through a bin2onehot model
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            v = 4'($urandom_range(0, 14));
            bus.in = bin2onehot(v);
            tick();
            chk("rt_out",     32'(bus.out), 32'(v));
            chk("rt_out_err", 32'(bus.out_err), 0);
        end
        $display("round trip done cnt=%0d", err_cnt);
        chk("rt_err_cnt", 32'(err_cnt), 0);

        v = 4'hF;
        w = bin2onehot(v);
        chk("rt15_word_not_onehot", 32'(onehot_ok(w)), 0);
        bus.in = w;
        tick();
        chk("rt15_out_err", 32'(bus.out_err), 1);
        chk("rt15_out",     32'(bus.out), 32'hF);
        chk("rt15_err_cnt", 32'(err_cnt), 1);
        $display("round trip v=15 out=%0h err=%0d", bus.out, bus.out_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
